// File: rtl/cdb_pkg.sv
// Shared constants for the common data bus arbiter: widths, requester indices
// and the ROB "waiting_for" tag encoding.
package cdb_pkg;

    localparam int N_REQ  = 6;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(N_REQ);

    localparam int REQ_ADD1  = 0;
    localparam int REQ_ADD2  = 1;
    localparam int REQ_ADD3  = 2;
    localparam int REQ_MULT1 = 3;
    localparam int REQ_MULT2 = 4;
    localparam int REQ_LS    = 5;

    localparam logic [TAG_W-1:0] TAG_NONE    = 4'd0;
    localparam logic [TAG_W-1:0] TAG_LS_BASE = 4'd1;
    localparam logic [TAG_W-1:0] TAG_ADD1    = 4'd7;
    localparam logic [TAG_W-1:0] TAG_ADD2    = 4'd8;
    localparam logic [TAG_W-1:0] TAG_ADD3    = 4'd9;
    localparam logic [TAG_W-1:0] TAG_MULT1   = 4'd10;
    localparam logic [TAG_W-1:0] TAG_MULT2   = 4'd11;

    // Round-robin successor of a winner index; the last requester wraps to 0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
        return (w == PTR_W'(N_REQ - 1)) ? '0 : w + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request at or after ptr
// (wrapping) wins; outputs a one-hot grant and the encoded winner.
module rr_arbiter #(
    parameter int N     = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one pending result per cycle round-robin and
// drives a registered {valid, tag, data} broadcast that is zero when idle.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      cdb_hold,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [2:0]                busy_cnt
);

    // Handshake: a result moves when req_valid[i] & req_ready[i] at a rising
    // edge. req_ready may follow req_valid combinationally, never the reverse.

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt;
    logic [PTR_W-1:0]  win_idx;
    logic              xfer;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign req_ready = (rst_n && !cdb_hold) ? gnt : '0;
    assign xfer      = |(req_valid & req_ready);
    assign busy_cnt  = 3'($countones(req_valid));

    // Idle cycles broadcast all zeros because consumers OR-match on the tag.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = TAG_NONE;
        cdb_data_d  = '0;
        if (xfer) begin
            rr_ptr_d    = ptr_after(win_idx);
            cdb_valid_d = 1'b1;
            cdb_tag_d   = req_tag[int'(win_idx)*TAG_W +: TAG_W];
            cdb_data_d  = req_data[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_NONE;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural model of requesters and the rotating grant.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_hold;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [2:0]              busy_cnt;

    cdb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_hold  (cdb_hold),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .busy_cnt  (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester state as the bench sees it, plus the model's pointer.
    logic              m_v   [N_REQ];
    logic [TAG_W-1:0]  m_tag [N_REQ];
    logic [DATA_W-1:0] m_data[N_REQ];
    int                m_ptr;
    logic              m_rst_n;
    logic              m_hold;

    int n_vec;
    int n_err;

    logic [N_REQ-1:0]  last_ready;
    logic [TAG_W-1:0]  last_tag;
    logic [DATA_W-1:0] last_data;
    logic              last_valid;
    int                last_win;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N_REQ; k++) begin
            if (m_v[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // One clock: drive, check combinational outputs, clock, check broadcast.
    task automatic cycle();
        int w;
        int cnt;
        logic [N_REQ-1:0]  exp_ready;
        logic              exp_valid;
        logic [TAG_W-1:0]  exp_tag;
        logic [DATA_W-1:0] exp_data;
        rst_n    = m_rst_n;
        cdb_hold = m_hold;
        cnt      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]                 = m_v[i];
            req_tag[i*TAG_W +: TAG_W]    = m_tag[i];
            req_data[i*DATA_W +: DATA_W] = m_data[i];
            if (m_v[i]) cnt++;
        end
        w = (m_rst_n && !m_hold) ? model_winner() : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        #1;
        last_ready = req_ready;
        last_win   = w;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy_cnt", 32'(busy_cnt), 32'(cnt));
        exp_valid = 1'b0;
        exp_tag   = '0;
        exp_data  = '0;
        if (!m_rst_n) begin
            m_ptr = 0;
        end else if (w >= 0) begin
            exp_valid = 1'b1;
            exp_tag   = m_tag[w];
            exp_data  = m_data[w];
            m_ptr     = (w + 1) % N_REQ;
            m_v[w]    = 1'b0;
        end
        @(posedge clk);
        #1;
        last_valid = cdb_valid;
        last_tag   = cdb_tag;
        last_data  = cdb_data;
        check("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
        check("cdb_tag", 32'(cdb_tag), 32'(exp_tag));
        check("cdb_data", cdb_data, exp_data);
    endtask

    task automatic post(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        m_v[i]    = 1'b1;
        m_tag[i]  = t;
        m_data[i] = d;
    endtask

    function automatic logic [TAG_W-1:0] legal_tag(input int i);
        if (i == REQ_LS) return TAG_LS_BASE + TAG_W'($urandom_range(0, 5));
        return TAG_ADD1 + TAG_W'(i);
    endfunction

    logic [TAG_W-1:0] fair_tags[N_REQ];

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ptr = 0;
        m_hold = 1'b0;
        m_rst_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        rst_n = 1'b0; cdb_hold = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        fair_tags = '{TAG_ADD1, TAG_ADD2, TAG_ADD3, TAG_MULT1, TAG_MULT2, 4'd3};
        @(posedge clk);
        #1;

        // Reset held with every requester pending, then fairness sweep.
        for (int i = 0; i < N_REQ; i++) post(i, fair_tags[i], 32'h100 + 32'(i));
        cycle();
        cycle();
        check("rst_ready", 32'(last_ready), 32'h0);
        check("rst_valid", 32'(last_valid), 32'h0);
        m_rst_n = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            cycle();
            check("fair_gnt", 32'(last_ready), 32'(1 << k));
            check("fair_tag", 32'(last_tag), 32'(fair_tags[k]));
        end
        cycle();
        check("idle_valid", 32'(last_valid), 32'h0);

        // Lone MULT1 request.
        post(REQ_MULT1, TAG_MULT1, 32'h0000_00FF);
        cycle();
        check("mult1_gnt", 32'(last_ready), 32'b001000);
        check("mult1_data", last_data, 32'h0000_00FF);
        cycle();
        check("mult1_after", 32'(last_tag), 32'h0);

        // Wrap from LS back to ADD1.
        post(REQ_MULT2, TAG_MULT2, 32'hAAAA);
        cycle();
        post(REQ_LS, 4'd6, 32'h5151);
        post(REQ_ADD1, TAG_ADD1, 32'h0A0A);
        cycle();
        check("wrap_ls", 32'(last_ready), 32'b100000);
        cycle();
        check("wrap_add1", 32'(last_ready), 32'b000001);

        // Back-pressure for three cycles with ADD2 waiting.
        post(REQ_ADD2, TAG_ADD2, 32'h2222);
        m_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_ready", 32'(last_ready), 32'h0);
            check("hold_valid", 32'(last_valid), 32'h0);
        end
        m_hold = 1'b0;
        cycle();
        check("unhold_gnt", 32'(last_ready), 32'b000010);
        check("unhold_tag", 32'(last_tag), 32'(TAG_ADD2));

        // ADD3 re-requests right after acceptance while MULT2 waits.
        post(REQ_ADD3, TAG_ADD3, 32'h0F0F);
        post(REQ_MULT2, TAG_MULT2, 32'hBEEF);
        cycle();
        post(REQ_ADD3, TAG_ADD3, 32'h1234);
        cycle();
        check("b2b_tag1", 32'(last_tag), 32'(TAG_MULT2));
        cycle();
        check("b2b_tag2", 32'(last_tag), 32'(TAG_ADD3));
        check("b2b_data2", last_data, 32'h1234);

        // Random traffic with occasional hold and reset.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!m_v[i] && $urandom_range(0, 2) == 0) post(i, legal_tag(i), $urandom);
            end
            m_hold  = ($urandom_range(0, 7) == 0);
            m_rst_n = ($urandom_range(0, 99) != 0);
            if (!m_rst_n) begin
                for (int i = 0; i < N_REQ; i++) m_v[i] = ($urandom_range(0, 1) == 1) ? m_v[i] : 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
